// File: rtl/puf_response_reader.sv
// Challenge issuer and response evaluator for a pair of ring-oscillator PUFs.
// A challenge is accepted in IDLE and driven to both PUFs. The PUFs are given
// a settle period, then the rising edges of each ring oscillator are counted
// over a fixed window. The two counts are returned with a comparison bit and a
// tie flag, and are held until the consumer takes the response.
module puf_response_reader #(
   parameter int CNT_W  = 16,
   parameter int SETTLE = 16,
   parameter int WINDOW = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [7:0]       req_chal,
   input  logic             req_s,
   output logic [7:0]       puf_c,
   output logic             puf_s,
   output logic             puf_en,
   input  logic             ro_a,
   input  logic             ro_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_bit,
   output logic             rsp_tie,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b
);

   // One shared phase timer covers both the settle and the counting phase.
   localparam int TMR_MAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
   localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_COUNT,
      ST_DONE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [TMR_W-1:0] timer;
   logic             accept;

   logic a_meta, a_sync, a_hist;
   logic b_meta, b_sync, b_hist;
   logic edge_a, edge_b;

   assign accept = req_valid & req_ready;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and handshake/enable outputs.
   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      puf_en     = 1'b0;
      rsp_valid  = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_next = ST_SETTLE;
         end
         ST_SETTLE: begin
            puf_en = 1'b1;
            if (timer == SETTLE_LAST) state_next = ST_COUNT;
         end
         ST_COUNT: begin
            puf_en = 1'b1;
            if (timer == WINDOW_LAST) state_next = ST_DONE;
         end
         ST_DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Phase timer restarts on every state change so each phase counts from 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer <= '0;
      end else if (state_next != state) begin
         timer <= '0;
      end else if (state == ST_SETTLE || state == ST_COUNT) begin
         timer <= timer + TMR_W'(1);
      end
   end

   // Challenge and polarity are captured only on an accepted request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         puf_c <= '0;
         puf_s <= 1'b0;
      end else if (accept) begin
         puf_c <= req_chal;
         puf_s <= req_s;
      end
   end

   // Two-flop synchronizers plus a history flop for rising-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_meta <= 1'b0;
         a_sync <= 1'b0;
         a_hist <= 1'b0;
         b_meta <= 1'b0;
         b_sync <= 1'b0;
         b_hist <= 1'b0;
      end else begin
         a_meta <= ro_a;
         a_sync <= a_meta;
         a_hist <= a_sync;
         b_meta <= ro_b;
         b_sync <= b_meta;
         b_hist <= b_sync;
      end
   end

   assign edge_a = a_sync & ~a_hist;
   assign edge_b = b_sync & ~b_hist;

   // Edge counters clear on acceptance, count only in COUNT and saturate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_a <= '0;
         cnt_b <= '0;
      end else if (accept) begin
         cnt_a <= '0;
         cnt_b <= '0;
      end else if (state == ST_COUNT) begin
         if (edge_a && (cnt_a != {CNT_W{1'b1}})) cnt_a <= cnt_a + CNT_W'(1);
         if (edge_b && (cnt_b != {CNT_W{1'b1}})) cnt_b <= cnt_b + CNT_W'(1);
      end
   end

   assign rsp_bit = (cnt_a > cnt_b);
   assign rsp_tie = (cnt_a == cnt_b);

endmodule

// File: tb/tb_puf_response_reader.sv
// Self-checking bench for puf_response_reader. Two instances share every
// input: a 16-bit one for the normal results and a 4-bit one that shows
// counter saturation. Expected results are queued when a request is accepted
// and compared when the response is presented.
module tb_puf_response_reader;

   localparam int S = 4;
   localparam int W = 100;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic [7:0]  req_chal;
   logic        req_s;
   logic        ro_a;
   logic        ro_b;
   logic        rsp_ready;

   logic        req_ready, puf_s, puf_en, rsp_valid, rsp_bit, rsp_tie;
   logic [7:0]  puf_c;
   logic [15:0] cnt_a, cnt_b;

   logic        s_req_ready, s_puf_s, s_puf_en, s_rsp_valid, s_rsp_bit, s_rsp_tie;
   logic [7:0]  s_puf_c;
   logic [3:0]  s_cnt_a, s_cnt_b;

   typedef struct {
      logic [7:0] chal;
      logic       s;
      int         cnt_a;
      int         cnt_b;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   puf_response_reader #(.CNT_W(16), .SETTLE(S), .WINDOW(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_chal(req_chal), .req_s(req_s),
      .puf_c(puf_c), .puf_s(puf_s), .puf_en(puf_en),
      .ro_a(ro_a), .ro_b(ro_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_bit(rsp_bit), .rsp_tie(rsp_tie),
      .cnt_a(cnt_a), .cnt_b(cnt_b)
   );

   puf_response_reader #(.CNT_W(4), .SETTLE(S), .WINDOW(W)) dut_small (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(s_req_ready),
      .req_chal(req_chal), .req_s(req_s),
      .puf_c(s_puf_c), .puf_s(s_puf_s), .puf_en(s_puf_en),
      .ro_a(ro_a), .ro_b(ro_b),
      .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
      .rsp_bit(s_rsp_bit), .rsp_tie(s_rsp_tie),
      .cnt_a(s_cnt_a), .cnt_b(s_cnt_b)
   );

   // Free-running system clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts one comparison and reports it if the observed value is wrong.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Oscillator level presented before edge k of a transaction.
   function automatic logic wave(input int k, input int half);
      if (half == 0) return 1'b0;
      return ((k / half) % 2) == 1;
   endfunction

   // Rising edges that land in the counted span, allowing for the two-cycle
   // synchronizer lag: a rise seen at edge k is counted at edge k+2.
   function automatic int expCount(input int half);
      int c = 0;
      for (int k = S - 1; k <= S + W - 2; k++)
         if (wave(k, half) && !wave(k - 1, half)) c++;
      return c;
   endfunction

   // Asynchronous reset values of both instances.
   task automatic resetChecks(input string tag);
      checkOutput({tag, "_req_ready"}, req_ready, 1);
      checkOutput({tag, "_puf_en"},    puf_en,    0);
      checkOutput({tag, "_puf_c"},     puf_c,     0);
      checkOutput({tag, "_puf_s"},     puf_s,     0);
      checkOutput({tag, "_rsp_valid"}, rsp_valid, 0);
      checkOutput({tag, "_rsp_bit"},   rsp_bit,   0);
      checkOutput({tag, "_rsp_tie"},   rsp_tie,   1);
      checkOutput({tag, "_cnt_a"},     cnt_a,     0);
      checkOutput({tag, "_cnt_b"},     cnt_b,     0);
      checkOutput({tag, "_s_cnt_a"},   s_cnt_a,   0);
   endtask

   // Runs one request from acceptance through the response handshake.
   task automatic applyStimulus(input string tag, input logic [7:0] chal, input logic s,
                                input int half_a, input int half_b, input int bp_cycles,
                                input bit busy, input int reset_at);
      exp_t e, got;
      int   sa, sb_cnt;
      for (int k = 0; k <= S + W; k++) begin
         @(negedge clk);
         ro_a = wave(k, half_a);
         ro_b = wave(k, half_b);
         if (k == 0) begin
            req_valid = 1'b1;
            req_chal  = chal;
            req_s     = s;
            checkOutput({tag, "_req_ready_pre"}, req_ready, 1);
            e.chal  = chal;
            e.s     = s;
            e.cnt_a = expCount(half_a);
            e.cnt_b = expCount(half_b);
            sb.push_back(e);
         end else if (busy && k >= S + 10) begin
            req_valid = 1'b1;
            req_chal  = 8'h3C;
            req_s     = ~s;
         end else begin
            req_valid = 1'b0;
         end
         @(posedge clk);
         #1;
         if (k == 0) begin
            checkOutput({tag, "_puf_en_on"}, puf_en, 1);
            checkOutput({tag, "_puf_c"},     puf_c,  chal);
            checkOutput({tag, "_puf_s"},     puf_s,  s);
            checkOutput({tag, "_busy_ready"}, req_ready, 0);
            checkOutput({tag, "_cnt_clr"},   cnt_a,  0);
         end
         if (reset_at >= 0 && k == reset_at) begin
            #1 rst_n = 1'b0;
            #1 resetChecks({tag, "_rst"});
            void'(sb.pop_front());
            @(negedge clk);
            @(negedge clk);
            rst_n     = 1'b1;
            req_valid = 1'b0;
            return;
         end
         if (busy && k == S + 10) begin
            checkOutput({tag, "_busy_puf_c"}, puf_c, chal);
            checkOutput({tag, "_busy_rdy"},   req_ready, 0);
         end
         if (k == S + W - 1) checkOutput({tag, "_valid_early"}, rsp_valid, 0);
         if (k == S + W) begin
            checkOutput({tag, "_valid_on"}, rsp_valid, 1);
            checkOutput({tag, "_puf_en_off"}, puf_en, 0);
         end
      end
      for (int i = 0; i < bp_cycles; i++) begin
         @(negedge clk);
         req_valid = 1'b1;
         req_chal  = 8'h3C;
         @(posedge clk);
         #1;
      end
      if (bp_cycles > 0) begin
         checkOutput({tag, "_bp_valid"},  rsp_valid, 1);
         checkOutput({tag, "_bp_ready"},  req_ready, 0);
         checkOutput({tag, "_bp_puf_en"}, puf_en,    0);
         checkOutput({tag, "_bp_puf_c"},  puf_c,     chal);
      end
      if (sb.size() == 0) begin
         checkOutput({tag, "_sb_empty"}, 1, 0);
      end else begin
         got    = sb.pop_front();
         sa     = (got.cnt_a > 15) ? 15 : got.cnt_a;
         sb_cnt = (got.cnt_b > 15) ? 15 : got.cnt_b;
         checkOutput({tag, "_cnt_a"},   cnt_a,   got.cnt_a);
         checkOutput({tag, "_cnt_b"},   cnt_b,   got.cnt_b);
         checkOutput({tag, "_bit"},     rsp_bit, got.cnt_a > got.cnt_b);
         checkOutput({tag, "_tie"},     rsp_tie, got.cnt_a == got.cnt_b);
         checkOutput({tag, "_s_cnt_a"}, s_cnt_a, sa);
         checkOutput({tag, "_s_cnt_b"}, s_cnt_b, sb_cnt);
         checkOutput({tag, "_s_bit"},   s_rsp_bit, sa > sb_cnt);
         @(negedge clk);
         req_valid = 1'b0;
         rsp_ready = 1'b1;
         @(posedge clk);
         #1;
         checkOutput({tag, "_done_valid"}, rsp_valid, 0);
         checkOutput({tag, "_done_ready"}, req_ready, 1);
         checkOutput({tag, "_hold_cnt_a"}, cnt_a, got.cnt_a);
         @(negedge clk);
         rsp_ready = 1'b0;
         @(posedge clk);
         #1;
         checkOutput({tag, "_idle_ready"}, req_ready, 1);
         checkOutput({tag, "_idle_valid"}, rsp_valid, 0);
      end
   endtask

   // Test sequence.
   initial begin
      rst_n     = 1'b1;
      req_valid = 1'b0;
      req_chal  = 8'h00;
      req_s     = 1'b0;
      ro_a      = 1'b0;
      ro_b      = 1'b0;
      rsp_ready = 1'b0;
      #1 rst_n = 1'b0;
      #2 resetChecks("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      applyStimulus("basic",    8'hA5, 1'b1, 4, 5, 0,  1'b0, -1);
      applyStimulus("tie",      8'h5A, 1'b0, 4, 4, 0,  1'b0, -1);
      applyStimulus("backpres", 8'h11, 1'b1, 3, 7, 50, 1'b0, -1);
      applyStimulus("saturate", 8'hF0, 1'b0, 1, 0, 0,  1'b0, -1);
      applyStimulus("busyreq",  8'h77, 1'b1, 5, 4, 0,  1'b1, -1);
      applyStimulus("midreset", 8'h99, 1'b1, 4, 5, 0,  1'b0, S + 30);
      applyStimulus("fresh",    8'hC3, 1'b0, 6, 2, 0,  1'b0, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
